fp_add_sequencer: RTL and testbench

Multi-cycle FSM that sequences the single-precision FP add datapath: operand swap muxes, alignment right shifter, big ALU, normalize shifters with exponent increment/decrement, and rounding muxes. It replaces free-running per-cycle control with a start/busy/done handshake. All controls are registered, Moore-style, and valid for exactly the state that owns them. Leading-zero count is bounded, so an all-zero ALU result terminates instead of hanging.

---
 rtl/fp_add_pkg.sv | 32 +++
 rtl/fp_lzc26.sv | 22 ++
 rtl/fp_add_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants, state codes and helpers for the FP add control sequencer.
package fp_add_pkg;

    localparam int unsigned FRAC_W    = 28;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAX_ALIGN = 25;
    localparam int unsigned CARRY_BIT = 26;
    localparam int unsigned MSB_BIT   = 25;
    localparam int unsigned MANT_W    = MSB_BIT + 1;
    localparam int unsigned DIFF_W    = 9;
    localparam int unsigned ALIGN_W   = 8;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned STATE_W   = 3;

    // Sequencer states, one per datapath phase
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ALIGN  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ADD    = 3'd2;
    localparam logic [STATE_W-1:0] ST_NORM   = 3'd3;
    localparam logic [STATE_W-1:0] ST_ROUND  = 3'd4;
    localparam logic [STATE_W-1:0] ST_RENORM = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

    // Shifting past the guard bits cannot change the result, so cap it
    function automatic logic [ALIGN_W-1:0] sat_align(input logic [ALIGN_W-1:0] mag);
        if (mag > ALIGN_W'(MAX_ALIGN)) begin
            return ALIGN_W'(MAX_ALIGN);
        end
        return mag;
    endfunction

endpackage

// File: rtl/fp_lzc26.sv
// Combinational leading-zero counter over the 26-bit mantissa field.
module fp_lzc26
    import fp_add_pkg::*;
(
    input  logic [MANT_W-1:0]  mant,
    output logic [SHIFT_W-1:0] count,
    output logic               all_zero
);

    // Highest set bit is scanned last, so it determines the count
    always_comb begin
        count = '0;
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (mant[i]) begin
                count = SHIFT_W'(int'(MANT_W) - 1 - i);
            end
        end
    end

    assign all_zero = (mant == '0);

endmodule

// File: rtl/fp_add_sequencer.sv
// Start/busy/done sequencer for the single-precision add datapath; all controls
// are registered and valid only in the state that owns them.
module fp_add_sequencer
    import fp_add_pkg::*;
(
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [DIFF_W-1:0]  exp_diff,
    input  logic [EXP_W-1:0]   exp_big,
    input  logic [FRAC_W-1:0]  alu_result,
    input  logic               round_carry,
    output logic               busy,
    output logic               done,
    output logic               swap_sel,
    output logic [ALIGN_W-1:0] align_shift,
    output logic               alu_go,
    output logic               norm_right_en,
    output logic               norm_left_en,
    output logic [SHIFT_W-1:0] norm_shift,
    output logic               exp_inc_en,
    output logic               exp_dec_en,
    output logic [EXP_W-1:0]   exp_adj,
    output logic               round_sel,
    output logic               zero_flag
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [EXP_W-1:0]   exp_big_q;
    logic [EXP_W-1:0]   exp_big_d;

    logic               busy_d;
    logic               done_d;
    logic               swap_d;
    logic [ALIGN_W-1:0] align_d;
    logic               alu_go_d;
    logic               right_d;
    logic               left_d;
    logic [SHIFT_W-1:0] shift_d;
    logic               inc_d;
    logic               dec_d;
    logic [EXP_W-1:0]   adj_d;
    logic               round_sel_d;
    logic               zero_d;

    logic [SHIFT_W-1:0] lz_count;
    logic               lz_all_zero;
    logic               unused_frac_msb;

    assign unused_frac_msb = alu_result[FRAC_W-1];

    fp_lzc26 u_lzc (
        .mant     (alu_result[MSB_BIT:0]),
        .count    (lz_count),
        .all_zero (lz_all_zero)
    );

    // Next state and next registered control values
    always_comb begin
        state_d     = state_q;
        exp_big_d   = exp_big_q;
        swap_d      = swap_sel;
        align_d     = align_shift;
        zero_d      = zero_flag;
        right_d     = 1'b0;
        left_d      = 1'b0;
        shift_d     = '0;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        adj_d       = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_ALIGN;
                    swap_d    = exp_diff[DIFF_W-1];
                    align_d   = sat_align(exp_diff[ALIGN_W-1:0]);
                    exp_big_d = exp_big;
                    zero_d    = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                    swap_d    = 1'b0;
                    align_d   = '0;
                    exp_big_d = '0;
                    zero_d    = 1'b0;
                end
            end
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD: begin
                state_d = ST_NORM;
                // Exact cancellation or a left shift that would underflow flushes to zero
                if ((!alu_result[CARRY_BIT] && lz_all_zero) ||
                    (!alu_result[CARRY_BIT] && (EXP_W'(lz_count) >= exp_big_q))) begin
                    zero_d = 1'b1;
                end else if (alu_result[CARRY_BIT]) begin
                    right_d = 1'b1;
                    shift_d = SHIFT_W'(1);
                    inc_d   = 1'b1;
                    adj_d   = EXP_W'(1);
                end else if (lz_count != '0) begin
                    left_d  = 1'b1;
                    shift_d = lz_count;
                    dec_d   = 1'b1;
                    adj_d   = EXP_W'(lz_count);
                end
            end
            ST_NORM: state_d = ST_ROUND;
            ST_ROUND: begin
                state_d = ST_RENORM;
                if (round_carry && !zero_flag) begin
                    right_d = 1'b1;
                    shift_d = SHIFT_W'(1);
                    inc_d   = 1'b1;
                    adj_d   = EXP_W'(1);
                end
            end
            ST_RENORM: state_d = ST_DONE;
            default: begin
                state_d   = ST_IDLE;
                swap_d    = 1'b0;
                align_d   = '0;
                exp_big_d = '0;
                zero_d    = 1'b0;
            end
        endcase

        busy_d      = (state_d == ST_ALIGN) || (state_d == ST_ADD) || (state_d == ST_NORM) ||
                      (state_d == ST_ROUND) || (state_d == ST_RENORM);
        done_d      = (state_d == ST_DONE);
        alu_go_d    = (state_d == ST_ADD);
        round_sel_d = (state_d == ST_ROUND);
    end

    // State and registered controls
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q       <= ST_IDLE;
            exp_big_q     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            swap_sel      <= 1'b0;
            align_shift   <= '0;
            alu_go        <= 1'b0;
            norm_right_en <= 1'b0;
            norm_left_en  <= 1'b0;
            norm_shift    <= '0;
            exp_inc_en    <= 1'b0;
            exp_dec_en    <= 1'b0;
            exp_adj       <= '0;
            round_sel     <= 1'b0;
            zero_flag     <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_big_q     <= exp_big_d;
            busy          <= busy_d;
            done          <= done_d;
            swap_sel      <= swap_d;
            align_shift   <= align_d;
            alu_go        <= alu_go_d;
            norm_right_en <= right_d;
            norm_left_en  <= left_d;
            norm_shift    <= shift_d;
            exp_inc_en    <= inc_d;
            exp_dec_en    <= dec_d;
            exp_adj       <= adj_d;
            round_sel     <= round_sel_d;
            zero_flag     <= zero_d;
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: directed and random operations checked per cycle
// against a phase-based reference model.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [8:0]  exp_diff;
    logic [7:0]  exp_big;
    logic [27:0] alu_result;
    logic        round_carry;
    logic        busy, done, swap_sel, alu_go, norm_right_en, norm_left_en;
    logic        exp_inc_en, exp_dec_en, round_sel, zero_flag;
    logic [7:0]  align_shift, exp_adj;
    logic [4:0]  norm_shift;
    logic [31:0] obs_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_sequencer dut (
        .clk           (clk),
        .res           (res),
        .start         (start),
        .exp_diff      (exp_diff),
        .exp_big       (exp_big),
        .alu_result    (alu_result),
        .round_carry   (round_carry),
        .busy          (busy),
        .done          (done),
        .swap_sel      (swap_sel),
        .align_shift   (align_shift),
        .alu_go        (alu_go),
        .norm_right_en (norm_right_en),
        .norm_left_en  (norm_left_en),
        .norm_shift    (norm_shift),
        .exp_inc_en    (exp_inc_en),
        .exp_dec_en    (exp_dec_en),
        .exp_adj       (exp_adj),
        .round_sel     (round_sel),
        .zero_flag     (zero_flag)
    );

    assign obs_vec = {1'b0, busy, done, swap_sel, align_shift, alu_go, norm_right_en,
                      norm_left_en, norm_shift, exp_inc_en, exp_dec_en, exp_adj,
                      round_sel, zero_flag};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected output vector for phase 1 (first cycle after accept) .. 6 (done cycle)
    function automatic logic [31:0] exp_vec(input int phase, input logic [8:0] diff,
                                            input logic [7:0] big, input logic [27:0] alu,
                                            input logic rc);
        logic       sw, bsy, dn, go, nr, nl, inc, dec, rs, zf, z;
        logic [7:0] al, adj, mag;
        logic [4:0] sh;
        int         n;
        if (phase == 0) return 32'h0;
        sw  = diff[8];
        mag = diff[7:0];
        al  = (mag > 8'd25) ? 8'd25 : mag;
        n = 26;
        for (int b = 25; b >= 0; b--) begin
            if (alu[b]) begin
                n = 25 - b;
                break;
            end
        end
        z = !alu[26] && ((n == 26) || (n >= int'(big)));
        bsy = (phase >= 1) && (phase <= 5);
        dn  = (phase == 6);
        go  = (phase == 2);
        rs  = (phase == 4);
        zf  = (phase >= 3) && z;
        nr = 1'b0; nl = 1'b0; inc = 1'b0; dec = 1'b0; sh = 5'd0; adj = 8'd0;
        if (phase == 3 && !z) begin
            if (alu[26]) begin
                nr = 1'b1; inc = 1'b1; sh = 5'd1; adj = 8'd1;
            end else if (n > 0) begin
                nl = 1'b1; dec = 1'b1; sh = 5'(n); adj = 8'(n);
            end
        end
        if (phase == 5 && rc && !z) begin
            nr = 1'b1; inc = 1'b1; sh = 5'd1; adj = 8'd1;
        end
        return {1'b0, bsy, dn, sw, al, go, nr, nl, sh, inc, dec, adj, rs, zf};
    endfunction

    // Called at a negedge; leaves the bench at the negedge of the done cycle
    task automatic run_op(input string tag, input logic [8:0] diff, input logic [7:0] big,
                          input logic [27:0] alu, input logic rc, input bit hold = 1'b0,
                          input int pulse_p = 0, input int abort_p = 0);
        exp_diff    = diff;
        exp_big     = big;
        alu_result  = alu;
        round_carry = rc;
        start       = 1'b1;
        for (int p = 1; p <= 6; p++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_p%0d", tag, p), obs_vec, exp_vec(p, diff, big, alu, rc));
            if (p == abort_p) return;
            start = hold || (p == pulse_p);
            // Operands are sampled at their edges; later changes must not leak through
            if (p == 1) begin
                exp_diff = 9'($urandom);
                exp_big  = 8'($urandom);
            end
            if (p == 3) alu_result = 28'($urandom);
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk);
        @(negedge clk);
        check(tag, obs_vec, 32'h0);
    endtask

    task automatic rand_op(input int idx, input bit hold, input int pulse_p);
        logic [27:0] alu, mask;
        logic [7:0]  big;
        int          mode, k;
        mode = $urandom_range(0, 3);
        if (mode == 0) begin
            alu = {2'b01, 26'($urandom)};
        end else if (mode == 1) begin
            alu = 28'h0;
        end else begin
            k    = $urandom_range(0, 25);
            mask = (28'd1 << k) - 28'd1;
            alu  = (28'd1 << k) | (28'($urandom) & mask);
        end
        big = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(31, 255));
        run_op($sformatf("rnd%0d", idx), 9'($urandom), big, alu, 1'($urandom), hold, pulse_p);
    endtask

    initial begin
        res = 1'b0; start = 1'b0; exp_diff = '0; exp_big = '0;
        alu_result = '0; round_carry = 1'b0;
        #1 check("reset_state", obs_vec, 32'h0);
        repeat (2) @(negedge clk);
        res = 1'b1;
        idle_check("idle_after_reset");

        run_op("ovf", 9'h003, 8'd130, 28'h4000000, 1'b0);
        idle_check("idle_ovf");
        run_op("cancel", 9'h100, 8'd130, 28'h0000400, 1'b0);
        idle_check("idle_cancel");
        run_op("sat_rc", 9'h0FF, 8'd100, 28'h2000000, 1'b1);
        idle_check("idle_sat");
        run_op("zero", 9'h010, 8'd100, 28'h0000000, 1'b1);
        idle_check("idle_zero");
        run_op("uflow", 9'h005, 8'd5, 28'h0000020, 1'b1);
        idle_check("idle_uflow");
        run_op("pulse2", 9'h011, 8'd60, 28'h0080000, 1'b0, 1'b0, 2);
        idle_check("idle_pulse2");
        run_op("pulse5", 9'h1F0, 8'd60, 28'h4000001, 1'b1, 1'b0, 5);
        idle_check("idle_pulse5");

        run_op("hold0", 9'h002, 8'd90, 28'h4ABCDEF, 1'b1, 1'b1);
        run_op("hold1", 9'h120, 8'd90, 28'h0001000, 1'b0, 1'b1);
        run_op("hold2", 9'h000, 8'd3, 28'h0000100, 1'b1, 1'b1);
        run_op("hold3", 9'h019, 8'd90, 28'h1000000, 1'b1, 1'b0);
        idle_check("idle_hold");

        // Asynchronous reset during NORM aborts the operation
        run_op("rst", 9'h004, 8'd90, 28'h0000400, 1'b1, 1'b0, 0, 3);
        #2 res = 1'b0;
        #1 check("rst_async", obs_vec, 32'h0);
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d", i), obs_vec, 32'h0);
        end
        start = 1'b0;
        res   = 1'b1;
        idle_check("idle_after_rst");
        run_op("post_rst", 9'h007, 8'd90, 28'h0000400, 1'b1);
        idle_check("idle_post_rst");

        for (int i = 0; i < 60; i++) begin
            bit hold;
            hold = (i != 59) && ($urandom_range(0, 3) == 0);
            rand_op(i, hold, $urandom_range(0, 5));
            if (!hold && ($urandom_range(0, 1) == 0)) idle_check($sformatf("idle_rnd%0d", i));
        end
        idle_check("idle_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
